// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cla_pkg
// Description : Shared constants and the per-stage control record for the
//               pipelined carry-lookahead adder.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

  // Width of one lookahead slice; every pipeline stage adds one such nibble.
  localparam int NIBBLE_W = 4;

  // Largest supported slice count (operands up to 32 bits).
  localparam int MAX_NIBBLES = 8;

  // Control part of a pipeline stage. The operand/sum lanes travel alongside
  // in W-wide arrays in the top level, because their width follows the
  // NIBBLES parameter of each instance.
  typedef struct packed {
    logic valid;  // stage holds a live beat
    logic carry;  // carry out of the nibble this stage just added
    logic a_msb;  // operand A sign bit, kept for the overflow flag
    logic b_msb;  // operand B sign bit, kept for the overflow flag
  } stage_t;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla_4bit.sv
`default_nettype none
// ============================================================================
// Module      : cla_4bit
// Description : Purely combinational 4-bit carry-lookahead adder. All four
//               internal carries and the carry-out are two-level
//               generate/propagate expressions of the inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Flattened lookahead: no carry depends on another computed carry.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign Cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign S = p ^ c;

endmodule : cla_4bit
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_adder
// Description : Valid/ready pipelined adder, one 4-bit lookahead slice per
//               stage with the slice carry registered between stages.
//               NIBBLES may range over 1..8 (W = 4*NIBBLES).
// Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout,
  output logic                          ovf
);

  localparam int W = NIBBLE_W * NIBBLES;

  logic   adv;

  stage_t         stage_q [NIBBLES];
  stage_t         stage_d [NIBBLES];
  logic [W-1:0]   arem_q  [NIBBLES];   // operand A, already-added nibbles shifted out
  logic [W-1:0]   arem_d  [NIBBLES];
  logic [W-1:0]   brem_q  [NIBBLES];
  logic [W-1:0]   brem_d  [NIBBLES];
  logic [W-1:0]   sacc_q  [NIBBLES];   // sum nibbles produced so far, in place
  logic [W-1:0]   sacc_d  [NIBBLES];

  // The whole pipe moves as one unit: it only stops when a finished result
  // is sitting at the output and the consumer refuses it. Bubbles advance too.
  assign adv      = !stage_q[NIBBLES-1].valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NIBBLES; k++) begin : g_stage
    logic [W-1:0] a_src;
    logic [W-1:0] b_src;
    logic [W-1:0] s_src;
    logic         c_src;
    logic         v_src;
    logic         am_src;
    logic         bm_src;
    logic [3:0]   s_nib;
    logic         c_out;

    if (k == 0) begin : g_first
      // First slice works directly on the incoming operands.
      assign a_src  = a;
      assign b_src  = b;
      assign s_src  = '0;
      assign c_src  = cin;
      assign v_src  = in_valid;
      assign am_src = a[W-1];
      assign bm_src = b[W-1];
    end else begin : g_next
      // Later slices consume what the previous stage registered.
      assign a_src  = arem_q[k-1];
      assign b_src  = brem_q[k-1];
      assign s_src  = sacc_q[k-1];
      assign c_src  = stage_q[k-1].carry;
      assign v_src  = stage_q[k-1].valid;
      assign am_src = stage_q[k-1].a_msb;
      assign bm_src = stage_q[k-1].b_msb;
    end

    // The lowest remaining nibble is always at [3:0] because each stage
    // shifts the consumed nibble out.
    cla_4bit u_cla (
      .A    (a_src[NIBBLE_W-1:0]),
      .B    (b_src[NIBBLE_W-1:0]),
      .Cin  (c_src),
      .S    (s_nib),
      .Cout (c_out)
    );

    assign arem_d[k]  = a_src >> NIBBLE_W;
    assign brem_d[k]  = b_src >> NIBBLE_W;
    assign sacc_d[k]  = s_src | (W'(s_nib) << (NIBBLE_W * k));
    assign stage_d[k] = '{valid: v_src, carry: c_out, a_msb: am_src, b_msb: bm_src};
  end

  // Stage registers: cleared on reset, loaded together whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NIBBLES; k++) begin
        stage_q[k] <= '0;
        arem_q[k]  <= '0;
        brem_q[k]  <= '0;
        sacc_q[k]  <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < NIBBLES; k++) begin
        stage_q[k] <= stage_d[k];
        arem_q[k]  <= arem_d[k];
        brem_q[k]  <= brem_d[k];
        sacc_q[k]  <= sacc_d[k];
      end
    end
  end

  // Outputs come straight from the last stage's registers; overflow is a
  // function of those registers only, so it is 0 after reset and frozen
  // during a stall like the rest of the result.
  assign out_valid = stage_q[NIBBLES-1].valid;
  assign sum       = sacc_q[NIBBLES-1];
  assign cout      = stage_q[NIBBLES-1].carry;
  assign ovf       = (stage_q[NIBBLES-1].a_msb == stage_q[NIBBLES-1].b_msb) &&
                     (sacc_q[NIBBLES-1][W-1] != stage_q[NIBBLES-1].a_msb);

endmodule : cla_pipe_adder
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe_adder
// Description : Self-checking bench for cla_pipe_adder (NIBBLES = 4) with an
//               arithmetic reference model and an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  cla_pipe_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_dlv = 0;
  bit   acc_f;
  bit   dlv_f;
  bit   chk_lat = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain wide addition plus the signed-overflow rule.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input int t);
    exp_t       m;
    logic [W:0] full;
    full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    m.s   = full[W-1:0];
    m.co  = full[W];
    m.ov  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    m.cyc = t;
    return m;
  endfunction

  // One clock cycle: drive at negedge, observe 1ns later, score, then clock.
  task automatic cycle(input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input bit ordy);
    exp_t e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
    #1;
    acc_f = in_valid && in_ready;
    dlv_f = out_valid && out_ready;
    check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
    if (out_valid) check("valid_has_exp", 64'(q.size() != 0), 64'd1);
    if (dlv_f && q.size() != 0) begin
      e = q.pop_front();
      check("sum",  64'(sum),  64'(e.s));
      check("cout", 64'(cout), 64'(e.co));
      check("ovf",  64'(ovf),  64'(e.ov));
      if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(N));
      n_dlv++;
    end
    if (acc_f) q.push_back(model(ia, ib, ic, cyc));
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    q.delete();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_sum",       64'(sum),       64'd0);
    check("rst_cout",      64'(cout),      64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && q.size() != 0; i++) idle();
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Directed check of the result currently presented, independent of the model.
  task automatic expect_out(input string tag, input logic [W-1:0] s,
                            input logic co, input logic ov);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"},   64'(sum),       64'(s));
    check({tag, "_cout"},  64'(cout),      64'(co));
    check({tag, "_ovf"},   64'(ovf),       64'(ov));
  endtask

  initial begin
    logic [W-1:0] ba [6];
    logic [W-1:0] bb [6];
    logic [W-1:0] snap_s;
    logic         snap_c;
    logic         snap_o;
    int           idx;
    int           base;
    int           acc_n;
    bit           ordy;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    do_reset();

    // Carry ripple through all four slices, with exact latency.
    chk_lat = 1'b1;
    cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    for (int i = 0; i < N - 1; i++) begin
      check("early_valid", 64'(out_valid), 64'd0);
      idle();
    end
    expect_out("ripple", 16'h0000, 1'b1, 1'b0);
    drain(10);

    // Signed overflow, positive and negative.
    cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    cycle(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
    idle();
    idle();
    expect_out("ovf_pos", 16'h8000, 1'b0, 1'b1);
    idle();
    expect_out("ovf_neg", 16'h0000, 1'b1, 1'b1);
    drain(10);

    // Back-to-back streaming; fixed latency on every beat means no gaps.
    base = n_dlv;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 16'(i * 16'h1111), 16'h0F0F, 1'(i & 1), 1'b1);
    drain(20);
    check("stream_count", 64'(n_dlv - base), 64'd8);

    // Backpressure: 5-cycle hold mid-stream.
    chk_lat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ba[i] = 16'($urandom);
      bb[i] = 16'($urandom);
    end
    base = n_dlv;
    idx  = 0;
    for (int c = 0; c < 40 && !(idx == 6 && q.size() == 0); c++) begin
      ordy = !(c >= 5 && c < 10);
      if (!ordy) begin
        out_ready = 1'b0;
        in_valid  = (idx < 6);
        #1;
        if (c == 5) begin
          snap_s = sum; snap_c = cout; snap_o = ovf;
        end
        check("hold_valid",    64'(out_valid), 64'd1);
        check("hold_in_ready", 64'(in_ready),  64'd0);
        check("hold_sum",      64'(sum),       64'(snap_s));
        check("hold_cout",     64'(cout),      64'(snap_c));
        check("hold_ovf",      64'(ovf),       64'(snap_o));
      end
      cycle(idx < 6, (idx < 6) ? ba[idx] : '0, (idx < 6) ? bb[idx] : '0, 1'b0, ordy);
      if (acc_f) idx++;
    end
    check("bp_accepted",  64'(idx), 64'd6);
    check("bp_delivered", 64'(n_dlv - base), 64'd6);

    // Reset with three beats in flight: none of them may ever appear.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      check("post_rst_valid", 64'(out_valid), 64'd0);
      idle();
    end
    chk_lat = 1'b1;
    cycle(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b1);
    for (int i = 0; i < N - 1; i++) idle();
    expect_out("after_rst", 16'h2345, 1'b0, 1'b0);
    drain(10);

    // Random traffic with random consumer backpressure.
    chk_lat = 1'b0;
    acc_n   = 0;
    for (int c = 0; c < 60000 && acc_n < 10000; c++) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
            1'($urandom), $urandom_range(0, 3) != 0);
      if (acc_f) acc_n++;
    end
    check("rand_accepted", 64'(acc_n), 64'd10000);
    drain(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cla_pipe_adder
`default_nettype wire
